// File: rtl/key_pulse.sv
// key_pulse: sync + debounce + press one-shot for two active-low keys.
// Define KEY_PULSE_TIE_DROP_EN to drop L and R when both fire in one cycle.
module key_pulse #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  // Bit 1 of the encoding is the debounced pressed level.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } state_t;

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  state_t        state    [2];
  state_t        state_nx [2];
  logic [CW-1:0] cnt      [2];
  logic [CW-1:0] cnt_nx   [2];
  logic [1:0]    ev;
  logic [1:0]    ev_nx;
  logic          tie;

  // Two-flop synchronizer, flipped to 1 = pressed (index 0 = left).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~{key_r_n, key_l_n};
      sync2 <= sync1;
    end
  end

  // Debounce state, counter and registered press event per channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
      ev <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      ev <= ev_nx;
    end
  end

  // Next state: a change is accepted after DEBOUNCE stable samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      ev_nx[i]    = 1'b0;
      unique case (state[i])
        RELEASED: begin
          if (sync2[i]) begin
            state_nx[i] = PRESS_WAIT;
            cnt_nx[i]   = ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = ZERO;
          end else if (cnt[i] >= LAST) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = ZERO;
            ev_nx[i]    = 1'b1;
          end else if (cnt[i] != CMAX) begin
            cnt_nx[i] = cnt[i] + ONE;
          end
        end
        PRESSED: begin
          if (!sync2[i]) begin
            state_nx[i] = RELEASE_WAIT;
            cnt_nx[i]   = ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = ZERO;
          end else if (cnt[i] >= LAST) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = ZERO;
          end else if (cnt[i] != CMAX) begin
            cnt_nx[i] = cnt[i] + ONE;
          end
        end
        default: begin
          state_nx[i] = RELEASED;
          cnt_nx[i]   = ZERO;
        end
      endcase
    end
  end

`ifdef KEY_PULSE_TIE_DROP_EN
  assign tie = ev[0] & ev[1];
`else
  assign tie = 1'b0;
`endif

  // One-cycle move pulses, suppressed by freeze or a dropped tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      L <= 1'b0;
      R <= 1'b0;
    end else begin
      L <= ev[0] & ~freeze & ~tie;
      R <= ev[1] & ~freeze & ~tie;
    end
  end

  assign held_l = state[0][1];
  assign held_r = state[1][1];

endmodule
